// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file with busy scoreboard.
package regfile_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  // Widest busy vector popcount accepts; callers zero-extend into it.
  localparam int MAX_DEPTH      = 256;

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Low bit of field idx inside a packed vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation acceptance, write-clears / reserve-sets, registered count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w0_en_i,
  input  logic [ADDR_WIDTH-1:0]   w0_addr_i,
  input  logic                    w1_en_i,
  input  logic [ADDR_WIDTH-1:0]   w1_addr_i,
  input  logic                    rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]   rsv_addr_i,
  output logic                    rsv_ack_o,
  output logic [2**ADDR_WIDTH-1:0] busy_o,
  output logic [ADDR_WIDTH:0]     busy_cnt_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             rsv_zero;
  logic [MAX_DEPTH-1:0] pc_vec;

  assign rsv_zero  = (ZERO_REG != 0) && (rsv_addr_i == '0);
  // Judged on the pre-edge busy bit, so a register being retired this cycle cannot be re-reserved.
  assign rsv_ack_o = rst_n && rsv_en_i && !busy_q[rsv_addr_i] && !rsv_zero;

  always_comb begin
    busy_d = busy_q;
    pc_vec = '0;
    if (w0_en_i)   busy_d[w0_addr_i]  = 1'b0;
    if (w1_en_i)   busy_d[w1_addr_i]  = 1'b0;
    if (rsv_ack_o) busy_d[rsv_addr_i] = 1'b1;
    pc_vec[DEPTH-1:0] = busy_d;
    busy_cnt_d = CW'(popcount(pc_vec));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (NUM_RD reads, 2 prioritized writes) with busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w0_en,
  input  logic [ADDR_WIDTH-1:0]        w0_addr,
  input  logic [DATA_WIDTH-1:0]        w0_data,
  input  logic                         w1_en,
  input  logic [ADDR_WIDTH-1:0]        w1_addr,
  input  logic [DATA_WIDTH-1:0]        w1_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         rsv_ack,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  wr0_ok, wr1_ok;

  assign wr0_ok = w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
  assign wr1_ok = w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

  // Lane 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_ok) mem_q[w0_addr] <= w0_data;
      if (wr1_ok) mem_q[w1_addr] <= w1_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .w0_en_i    (w0_en),
    .w0_addr_i  (w0_addr),
    .w1_en_i    (w1_en),
    .w1_addr_i  (w1_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .rsv_ack_o  (rsv_ack),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    localparam int ALO = slice_lo(p, ADDR_WIDTH);
    localparam int DLO = slice_lo(p, DATA_WIDTH);
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  rbusy;

    assign ra = rd_addr[ALO +: ADDR_WIDTH];

    always_comb begin
      rdat  = mem_q[ra];
      rbusy = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (w1_en && (w1_addr == ra)) begin
        rdat  = w1_data;
        rbusy = 1'b0;
      end else if (w0_en && (w0_addr == ra)) begin
        rdat  = w0_data;
        rbusy = 1'b0;
      end
`endif
      // Hardwired zero overrides forwarding as well.
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
    end

    assign rd_data[DLO +: DATA_WIDTH] = rdat;
    assign rd_busy[p]                 = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: random + directed stimulus against an array model.
module tb_regfile_mp_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  localparam int W  = 1 + (AW + 1) + NR + NR * DW;

  logic               clk;
  logic               rst_n;
  logic               w0_en, w1_en, rsv_en;
  logic [AW-1:0]      w0_addr, w1_addr, rsv_addr;
  logic [DW-1:0]      w0_data, w1_data;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_busy;
  logic               rsv_ack;
  logic [AW:0]        busy_cnt;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  regfile_mp_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w0_en    (w0_en),
    .w0_addr  (w0_addr),
    .w0_data  (w0_data),
    .w1_en    (w1_en),
    .w1_addr  (w1_addr),
    .w1_data  (w1_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ack  (rsv_ack),
    .busy_cnt (busy_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    w0_en = 0; w0_addr = '0; w0_data = '0;
    w1_en = 0; w1_addr = '0; w1_data = '0;
    rsv_en = 0; rsv_addr = '0; rd_addr = '0;
  endtask

  // Asserts reset immediately; caller makes sure no expected entry is pending.
  task automatic do_reset();
    rst_n = 1'b0;
    w0_en = 0; w1_en = 0;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    rd_addr = {5'd5, 5'd3};
    #1;
    check("rst_rd_data",  64'(rd_data),  64'd0);
    check("rst_rd_busy",  64'(rd_busy),  64'd0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("rst_rsv_ack",  64'(rsv_ack),  64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 0;
    end
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  // Expected outputs for the current inputs, from the pre-edge model.
  function automatic logic [W-1:0] model_out();
    logic [NR*DW-1:0] dat;
    logic [NR-1:0]    bsy;
    logic             ack;
    logic [AW:0]      cnt;
    logic [AW-1:0]    a;
    logic [NR*AW-1:0] ra_vec;
    ra_vec = rd_addr;
    dat = '0;
    bsy = '0;
    for (int p = 0; p < NR; p++) begin
      a = ra_vec[p*AW +: AW];
      dat[p*DW +: DW] = m_mem[a];
      bsy[p]          = m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (w1_en && w1_addr == a) begin
        dat[p*DW +: DW] = w1_data; bsy[p] = 0;
      end else if (w0_en && w0_addr == a) begin
        dat[p*DW +: DW] = w0_data; bsy[p] = 0;
      end
`endif
      if (a == 0) begin
        dat[p*DW +: DW] = '0; bsy[p] = 0;
      end
    end
    ack = rsv_en && !m_busy[rsv_addr] && (rsv_addr != 0);
    cnt = (AW+1)'(model_cnt());
    return {ack, cnt, bsy, dat};
  endfunction

  task automatic model_edge();
    bit ack;
    ack = rsv_en && !m_busy[rsv_addr] && (rsv_addr != 0);
    if (w0_en && w0_addr != 0) m_mem[w0_addr] = w0_data;
    if (w1_en && w1_addr != 0) m_mem[w1_addr] = w1_data;
    if (w0_en) m_busy[w0_addr] = 0;
    if (w1_en) m_busy[w1_addr] = 0;
    if (ack)   m_busy[rsv_addr] = 1;
  endtask

  // driver task: one clock of stimulus, expected response queued for the monitor
  task automatic cycle(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    @(posedge clk);
    #1;
    w0_en = e0; w0_addr = a0; w0_data = d0;
    w1_en = e1; w1_addr = a1; w1_data = d1;
    rsv_en = re; rsv_addr = ra;
    rd_addr = {p1, p0};
    exp_q.push_back(model_out());
    model_edge();
  endtask

  task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, p0, p1);
  endtask

  // monitor / scoreboard: outputs are presented every cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {rsv_ack, busy_cnt, rd_busy, rd_data};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_out t=%0t act=%h exp=%h", $time, a, e);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    for (int i = 0; i < DEPTH; i += 2) rd(5'(i), 5'(i + 1));

    // reset in the middle of a write to reg 5
    @(posedge clk);
    #1;
    w0_en = 1; w0_addr = 5'd5; w0_data = 32'hCAFE_F00D;
    #2;
    do_reset();
    rd(5'd5, 5'd5);

    cycle(1, 5'd3, 32'hDEADBEEF, 1, 5'd3, 32'h12345678, 0, 0, 5'd3, 5'd0);
    rd(5'd3, 5'd3);
    cycle(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 5'd0, 5'd3);
    rd(5'd0, 5'd0);

    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3);
    cycle(1, 5'd7, 32'h0000_0777, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    rd(5'd7, 5'd3);

    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    cycle(0, 0, 0, 1, 5'd9, 32'h9999_0009, 1, 5'd9, 5'd9, 5'd9);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    rd(5'd9, 5'd0);

    for (int i = 1; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i - 1));
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd31);
    rd(5'd31, 5'd1);

    @(negedge clk);
    #1;
    do_reset();
    cycle(1, 5'd4, 32'h1111_1111, 0, 0, 0, 0, 0, 5'd4, 5'd0);
    cycle(1, 5'd4, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 5'd4, 5'd4);
    cycle(0, 0, 0, 1, 5'd4, 32'h5A5A_5A5A, 0, 0, 5'd0, 5'd4);
    rd(5'd4, 5'd4);

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a0, a1, ra, p0, p1;
      a0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ra = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      p0 = $urandom_range(0, 1) ? a0 : 5'($urandom_range(0, 31));
      p1 = $urandom_range(0, 1) ? a1 : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 3) == 0), a0, $urandom,
            1'($urandom_range(0, 3) == 0), a1, $urandom,
            1'($urandom_range(0, 1)), ra, p0, p1);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
